// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises ps2_clk/ps2_data, deframes 11-bit frames
// and queues valid scan codes in a first-word-fall-through FIFO. Optional macro: PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2     = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       sampling,
    output logic       frame_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [2:0]    clk_sync_reg;
    logic [1:0]    data_sync_reg;
    logic          fall;
    logic          sampling_reg;
    logic          bit_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;
    logic          frame_ok;
    logic          push;
    logic          frame_err_reg;
    logic          timeout_hit;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] w_ptr_reg;
    logic [PW-1:0] r_ptr_reg;
    logic [PW-1:0] count_reg;
    logic          overflow_reg;
    logic          pop;
    logic          accept;

    assign fall = !clk_sync_reg[1] && clk_sync_reg[2];

    // Synchronisers idle high so a reset never produces a spurious falling edge.
    always_ff @(posedge clk) begin
        if (clrn) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 2'b11;
            sampling_reg  <= 1'b0;
            bit_reg       <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            sampling_reg  <= fall;
            bit_reg       <= data_sync_reg[1];
        end
    end

    // shift_reg holds start, d0..d7, parity; bit_reg is the stop bit on the last sample.
    assign frame_ok = !shift_reg[0] && bit_reg && (^shift_reg[9:1]);
    assign push     = sampling_reg && (bit_cnt_reg == 4'd10) && frame_ok;

    always_ff @(posedge clk) begin
        if (clrn) begin
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 10'd0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (sampling_reg) begin
                if (bit_cnt_reg == 4'd10) begin
                    bit_cnt_reg   <= 4'd0;
                    frame_err_reg <= !frame_ok;
                end else begin
                    shift_reg[bit_cnt_reg] <= bit_reg;
                    bit_cnt_reg            <= bit_cnt_reg + 4'd1;
                end
            end else if (timeout_hit) begin
                bit_cnt_reg   <= 4'd0;
                frame_err_reg <= 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_reg;

    assign timeout_hit = !sampling_reg && (bit_cnt_reg != 4'd0)
                         && (to_cnt_reg == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (clrn || sampling_reg || (bit_cnt_reg == 4'd0) || timeout_hit)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_reg + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign pop    = (count_reg != '0) && !nextdata_n;
    assign accept = push && ((count_reg < PW'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (accept)
            mem[w_ptr_reg[DEPTH_LOG2-1:0]] <= shift_reg[8:1];
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            w_ptr_reg    <= '0;
            r_ptr_reg    <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept)
                w_ptr_reg <= w_ptr_reg + 1'b1;
            if (pop)
                r_ptr_reg <= r_ptr_reg + 1'b1;
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && !accept)
                overflow_reg <= 1'b1;
        end
    end

    assign data      = mem[r_ptr_reg[DEPTH_LOG2-1:0]];
    assign ready     = (count_reg != '0);
    assign overflow  = overflow_reg;
    assign sampling  = sampling_reg;
    assign frame_err = frame_err_reg;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed testbench for ps2_rx_fifo: hand-built PS/2 frames, FIFO fill/drain, overflow,
// parity error, reset mid-frame and (with PS2_RX_TIMEOUT_EN) the partial-frame timeout.
module tb_ps2_rx_fifo;
    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       sampling;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int samp_cnt = 0;
    int ferr_cnt = 0;

    logic ready_at_stop, ready_after, ferr_after, stop_seen;
    logic [7:0] data_after;

    ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
        .sampling(sampling), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sampling === 1'b1) samp_cnt <= samp_cnt + 1;
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits of a frame; on the stop bit, captures outputs around its sample.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit pop_at_stop);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                int k = 0;
                while (sampling !== 1'b1 && k < 10) begin
                    @(negedge clk);
                    k++;
                end
                stop_seen     = sampling;
                ready_at_stop = ready;
                if (pop_at_stop) nextdata_n = 1'b0;
                @(negedge clk);
                nextdata_n  = 1'b1;
                ready_after = ready;
                data_after  = data;
                ferr_after  = frame_err;
                repeat (4) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_one();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        int s0, f0;
        clrn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sampling", sampling, 0);
        check("rst_frame_err", frame_err, 0);
        clrn = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single frame 0x1C
        s0 = samp_cnt;
        send_frame(8'h1C, 0, 11, 0);
        check("t1_samples", samp_cnt - s0, 11);
        check("t1_stop_seen", stop_seen, 1);
        check("t1_ready_at_stop", ready_at_stop, 0);
        check("t1_ready_after", ready_after, 1);
        check("t1_data_after", data_after, 8'h1C);
        check("t1_ferr_after", ferr_after, 0);

        // 2: second frame 0xF0, drain both
        send_frame(8'hF0, 0, 11, 0);
        check("t2_data0", data, 8'h1C);
        pop_one();
        check("t2_ready1", ready, 1);
        check("t2_data1", data, 8'hF0);
        pop_one();
        check("t2_ready_empty", ready, 0);
        pop_one();
        check("t2_pop_empty_ignored", ready, 0);

        // 3: parity error then good frame 0x32
        f0 = ferr_cnt;
        send_frame(8'h1C, 1, 11, 0);
        check("t3_ferr_after", ferr_after, 1);
        check("t3_ferr_pulses", ferr_cnt - f0, 1);
        check("t3_ready", ready, 0);
        check("t3_overflow", overflow, 0);
        send_frame(8'h32, 0, 11, 0);
        check("t3_ready_good", ready, 1);
        check("t3_data_good", data, 8'h32);
        pop_one();
        check("t3_ready_empty", ready, 0);

        // 4: overflow after 9 frames without pops
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 11, 0);
        check("t4_overflow_full", overflow, 0);
        send_frame(8'h09, 0, 11, 0);
        check("t4_overflow_set", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t4_pop%0d", i), data, 32'(i));
            pop_one();
        end
        check("t4_ready_empty", ready, 0);
        check("t4_overflow_sticky", overflow, 1);
        clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        check("t4_overflow_cleared", overflow, 0);

        // 5: full FIFO, 9th push coincides with a pop
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 11, 0);
        send_frame(8'h09, 0, 11, 1);
        check("t5_overflow", overflow, 0);
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("t5_pop%0d", i), data, 32'(i));
            pop_one();
        end
        check("t5_ready_empty", ready, 0);

        // 6: reset mid-frame, then 0x5A
        send_frame(8'h77, 0, 5, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(8'h5A, 0, 11, 0);
        check("t6_ready", ready, 1);
        check("t6_data", data, 8'h5A);
        pop_one();
        check("t6_ready_empty", ready, 0);

`ifdef PS2_RX_TIMEOUT_EN
        f0 = ferr_cnt;
        send_frame(8'h33, 0, 4, 0);
        repeat (130) @(negedge clk);
        check("t6_timeout_ferr", ferr_cnt - f0, 1);
        check("t6_timeout_ready", ready, 0);
        send_frame(8'h5A, 0, 11, 0);
        check("t6_to_ready", ready, 1);
        check("t6_to_data", data, 8'h5A);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
